// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_timing
// Purpose  : 640x480@60 Hz VGA raster generator. It divides the system clock
//            into pixel ticks, walks the (DrawX, DrawY) scan position over the
//            full 800x525 raster, and decodes sync and blank from it. It also
//            provides line/frame strobes and a wrapping frame counter for game
//            logic.
// Ports    : i_clk          system clock (50 MHz)
//            i_rst_n        asynchronous active-low reset
//            o_pix_en       one-clk pixel-tick strobe
//            o_draw_x       current column, 0..H_TOTAL-1
//            o_draw_y       current line, 0..V_TOTAL-1
//            o_vga_hs       horizontal sync, active low
//            o_vga_vs       vertical sync, active low
//            o_vga_blank_n  high only inside the visible window
//            o_vga_sync_n   constant 0
//            o_vga_clk      50% duty pixel clock to the DAC
//            o_line_start   one-clk pulse when DrawX becomes 0
//            o_frame_start  one-clk pulse when (DrawX, DrawY) becomes (0,0)
//            o_frame_count  frames started since reset, wraps 255 -> 0
// Options  : VGA_SCAN_TIMING_ALIGN_EN -- when defined, HS/VS/BLANK_N are
//            delayed by one pixel tick so they line up with a registered
//            color stage downstream.
// Revision : 1.0  initial release
// ============================================================================
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_pix_en,
  output logic [9:0] o_draw_x,
  output logic [9:0] o_draw_y,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_vga_blank_n,
  output logic       o_vga_sync_n,
  output logic       o_vga_clk,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_frame_count
);

  localparam int               c_div_w    = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  localparam logic [9:0] c_h_vis   = 10'(H_VISIBLE);
  localparam logic [9:0] c_hs_beg  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_h_last  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_v_vis   = 10'(V_VISIBLE);
  localparam logic [9:0] c_vs_beg  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] c_v_last  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [c_div_w-1:0] r_div;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic               r_pix_en;
  logic               r_vga_clk;
  logic               r_hs;
  logic               r_vs;
  logic               r_blank_n;
  logic               r_line_start;
  logic               r_frame_start;
  logic [7:0]         r_frame_count;

  logic               w_tick;
  logic [c_div_w-1:0] w_div_nxt;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic               w_line;
  logic               w_frame;
  logic [9:0]         w_x_nxt;
  logic [9:0]         w_y_nxt;
  logic               w_hs_nxt;
  logic               w_vs_nxt;
  logic               w_blank_n_nxt;

  // The counters advance on the edge that closes the pix_en cycle, i.e. the
  // edge seen while the divider sits at its last value.
  assign w_tick    = (r_div == c_div_last);
  assign w_div_nxt = w_tick ? '0 : (r_div + c_div_one);
  assign w_x_wrap  = (r_x == c_h_last);
  assign w_y_wrap  = (r_y == c_v_last);
  assign w_line    = w_tick && w_x_wrap;
  assign w_frame   = w_line && w_y_wrap;

  assign w_x_nxt = !w_tick ? r_x : (w_x_wrap ? 10'd0 : (r_x + 10'd1));
  assign w_y_nxt = !w_line ? r_y : (w_y_wrap ? 10'd0 : (r_y + 10'd1));

  // Decoding from the next-state position makes sync/blank change on the
  // same edge as the coordinates they describe.
  assign w_hs_nxt      = !((w_x_nxt >= c_hs_beg) && (w_x_nxt <= c_hs_end));
  assign w_vs_nxt      = !((w_y_nxt >= c_vs_beg) && (w_y_nxt <= c_vs_end));
  assign w_blank_n_nxt = (w_x_nxt < c_h_vis) && (w_y_nxt < c_v_vis);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_x           <= c_h_last;
      r_y           <= c_v_last;
      r_pix_en      <= 1'b0;
      r_vga_clk     <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_div         <= w_div_nxt;
      // pix_en and VGA_CLK are registered copies of what the divider will hold
      // after this edge, so they are aligned with r_div.
      r_pix_en      <= (w_div_nxt == c_div_last);
      r_vga_clk     <= (w_div_nxt >= c_div_half);
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_blank_n     <= w_blank_n_nxt;
      r_line_start  <= w_line;
      r_frame_start <= w_frame;
      if (w_frame) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_SCAN_TIMING_ALIGN_EN
  logic r_hs_d;
  logic r_vs_d;
  logic r_blank_n_d;

  // One-tick delay: on each tick edge capture the decode of the position
  // being left, so the pins describe the pixel a registered color stage is
  // presenting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_blank_n_d <= 1'b0;
    end else if (w_tick) begin
      r_hs_d      <= r_hs;
      r_vs_d      <= r_vs;
      r_blank_n_d <= r_blank_n;
    end
  end

  assign o_vga_hs      = r_hs_d;
  assign o_vga_vs      = r_vs_d;
  assign o_vga_blank_n = r_blank_n_d;
`else
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_vga_blank_n = r_blank_n;
`endif

  assign o_pix_en      = r_pix_en;
  assign o_draw_x      = r_x;
  assign o_draw_y      = r_y;
  assign o_vga_sync_n  = 1'b0;
  assign o_vga_clk     = r_vga_clk;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_timing
// Purpose  : Directed self-checking bench for vga_scan_timing. Instance A uses
//            the full 640x480 timing for reset, line wrap, horizontal sync
//            and mid-frame reset. Instance B uses a tiny raster (8x7 ticks,
//            CLK_DIV=4) so vertical sync, frame wrap, the VGA_CLK duty cycle
//            and the 256-frame counter wrap fit in a short run.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_timing;

`ifdef VGA_SCAN_TIMING_ALIGN_EN
  localparam bit c_align = 1'b1;
`else
  localparam bit c_align = 1'b0;
`endif

  logic       r_clk = 1'b0;
  logic       r_rst_n_a = 1'b0;
  logic       r_rst_n_b = 1'b0;

  logic       w_a_pix, w_a_hs, w_a_vs, w_a_blank, w_a_sync, w_a_vclk, w_a_ls, w_a_fs;
  logic [9:0] w_a_x, w_a_y;
  logic [7:0] w_a_fc;
  logic       w_b_pix, w_b_hs, w_b_vs, w_b_blank, w_b_sync, w_b_vclk, w_b_ls, w_b_fs;
  logic [9:0] w_b_x, w_b_y;
  logic [7:0] w_b_fc;

  int checks = 0;
  int errors = 0;

  always #5 r_clk = ~r_clk;

  vga_scan_timing u_dut_a (
    .i_clk(r_clk), .i_rst_n(r_rst_n_a),
    .o_pix_en(w_a_pix), .o_draw_x(w_a_x), .o_draw_y(w_a_y),
    .o_vga_hs(w_a_hs), .o_vga_vs(w_a_vs), .o_vga_blank_n(w_a_blank),
    .o_vga_sync_n(w_a_sync), .o_vga_clk(w_a_vclk),
    .o_line_start(w_a_ls), .o_frame_start(w_a_fs), .o_frame_count(w_a_fc)
  );

  vga_scan_timing #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4)
  ) u_dut_b (
    .i_clk(r_clk), .i_rst_n(r_rst_n_b),
    .o_pix_en(w_b_pix), .o_draw_x(w_b_x), .o_draw_y(w_b_y),
    .o_vga_hs(w_b_hs), .o_vga_vs(w_b_vs), .o_vga_blank_n(w_b_blank),
    .o_vga_sync_n(w_b_sync), .o_vga_clk(w_b_vclk),
    .o_line_start(w_b_ls), .o_frame_start(w_b_fs), .o_frame_count(w_b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic wait_xy_a(input int x, input int y, input int budget);
    int n = 0;
    while (!(w_a_x == 10'(x) && w_a_y == 10'(y)) && n < budget) begin
      step(1);
      n++;
    end
    chk("a_reach_xy", 32'(w_a_x == 10'(x) && w_a_y == 10'(y)), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_x"},      32'(w_a_x), 32'd799);
    chk({tag, "_y"},      32'(w_a_y), 32'd524);
    chk({tag, "_hs"},     32'(w_a_hs), 32'd1);
    chk({tag, "_vs"},     32'(w_a_vs), 32'd1);
    chk({tag, "_blank"},  32'(w_a_blank), 32'd0);
    chk({tag, "_fc"},     32'(w_a_fc), 32'd0);
    chk({tag, "_pix"},    32'(w_a_pix), 32'd0);
    chk({tag, "_vclk"},   32'(w_a_vclk), 32'd0);
    chk({tag, "_ls"},     32'(w_a_ls), 32'd0);
    chk({tag, "_fs"},     32'(w_a_fs), 32'd0);
    chk({tag, "_sync_n"}, 32'(w_a_sync), 32'd0);
  endtask

  // Release reset on A (caller is just past a rising edge) and check the
  // first tick rolls the raster to (0,0) with both strobes and fc = 1.
  task automatic release_a(input string tag);
    r_rst_n_a = 1'b1;
    step(1);
    chk({tag, "_pix1"},   32'(w_a_pix), 32'd1);
    chk({tag, "_x_hold"}, 32'(w_a_x), 32'd799);
    chk({tag, "_vclk1"},  32'(w_a_vclk), 32'd1);
    step(1);
    chk({tag, "_x0"},     32'(w_a_x), 32'd0);
    chk({tag, "_y0"},     32'(w_a_y), 32'd0);
    chk({tag, "_blank0"}, 32'(w_a_blank), c_align ? 32'd0 : 32'd1);
    chk({tag, "_ls0"},    32'(w_a_ls), 32'd1);
    chk({tag, "_fs0"},    32'(w_a_fs), 32'd1);
    chk({tag, "_fc0"},    32'(w_a_fc), 32'd1);
    chk({tag, "_pix0"},   32'(w_a_pix), 32'd0);
    chk({tag, "_hs0"},    32'(w_a_hs), 32'd1);
    step(1);
    chk({tag, "_ls_end"}, 32'(w_a_ls), 32'd0);
    chk({tag, "_fs_end"}, 32'(w_a_fs), 32'd0);
    chk({tag, "_x_still0"}, 32'(w_a_x), 32'd0);
  endtask

  initial begin
    // ---------------- instance A: reset and first tick ----------------
    step(5);
    check_reset_a("a_rst");
    release_a("a_rel");

    // ---------------- line wrap at (799,10) ----------------
    wait_xy_a(799, 10, 20000);
    chk("a_799_hs",    32'(w_a_hs), 32'd1);
    chk("a_799_blank", 32'(w_a_blank), 32'd0);
    chk("a_799_ls",    32'(w_a_ls), 32'd0);
    step(2);
    chk("a_wrap_x",     32'(w_a_x), 32'd0);
    chk("a_wrap_y",     32'(w_a_y), 32'd11);
    chk("a_wrap_ls",    32'(w_a_ls), 32'd1);
    chk("a_wrap_fs",    32'(w_a_fs), 32'd0);
    chk("a_wrap_fc",    32'(w_a_fc), 32'd1);
    chk("a_wrap_blank", 32'(w_a_blank), c_align ? 32'd0 : 32'd1);
    step(1599);
    chk("a_ls_gap",     32'(w_a_ls), 32'd0);
    step(1);
    chk("a_ls_1600",    32'(w_a_ls), 32'd1);
    chk("a_ls_1600_y",  32'(w_a_y), 32'd12);

    // ---------------- blank and horizontal sync on line 12 ----------------
    step(1278);
    chk("a_x639",       32'(w_a_x), 32'd639);
    chk("a_blank_639",  32'(w_a_blank), 32'd1);
    step(2);
    chk("a_blank_640",  32'(w_a_blank), c_align ? 32'd1 : 32'd0);
    step(30);
    chk("a_hs_655",     32'(w_a_hs), 32'd1);
    step(2);
    chk("a_x656",       32'(w_a_x), 32'd656);
    chk("a_hs_656",     32'(w_a_hs), c_align ? 32'd1 : 32'd0);
    step(2);
    chk("a_hs_657",     32'(w_a_hs), 32'd0);
    step(188);
    chk("a_x751",       32'(w_a_x), 32'd751);
    chk("a_hs_751",     32'(w_a_hs), 32'd0);
    step(2);
    chk("a_hs_752",     32'(w_a_hs), c_align ? 32'd0 : 32'd1);
    chk("a_vs_line12",  32'(w_a_vs), 32'd1);

    // ---------------- asynchronous reset mid-frame ----------------
    wait_xy_a(300, 13, 3000);
    chk("a_fc_before_rst", 32'(w_a_fc), 32'd1);
    r_rst_n_a = 1'b0;
    #1;
    check_reset_a("a_mid_rst");
    step(5);
    check_reset_a("a_mid_hold");
    release_a("a_rerel");

    // ---------------- instance B: reset, divider, VGA_CLK ----------------
    chk("b_rst_x",     32'(w_b_x), 32'd7);
    chk("b_rst_y",     32'(w_b_y), 32'd6);
    chk("b_rst_fc",    32'(w_b_fc), 32'd0);
    chk("b_rst_blank", 32'(w_b_blank), 32'd0);
    r_rst_n_b = 1'b1;
    step(1);
    chk("b_d1_vclk", 32'(w_b_vclk), 32'd0);
    chk("b_d1_pix",  32'(w_b_pix), 32'd0);
    step(1);
    chk("b_d2_vclk", 32'(w_b_vclk), 32'd1);
    chk("b_d2_pix",  32'(w_b_pix), 32'd0);
    step(1);
    chk("b_d3_vclk", 32'(w_b_vclk), 32'd1);
    chk("b_d3_pix",  32'(w_b_pix), 32'd1);
    chk("b_d3_x",    32'(w_b_x), 32'd7);
    step(1);
    chk("b_00_x",    32'(w_b_x), 32'd0);
    chk("b_00_y",    32'(w_b_y), 32'd0);
    chk("b_00_fs",   32'(w_b_fs), 32'd1);
    chk("b_00_fc",   32'(w_b_fc), 32'd1);
    chk("b_00_vclk", 32'(w_b_vclk), 32'd0);
    chk("b_00_blank", 32'(w_b_blank), c_align ? 32'd0 : 32'd1);

    // ---------------- instance B: blank, HS, VS, frame wrap ----------------
    step(76);
    chk("b_32_x",     32'(w_b_x), 32'd3);
    chk("b_32_y",     32'(w_b_y), 32'd2);
    chk("b_32_blank", 32'(w_b_blank), 32'd1);
    step(4);
    chk("b_42_blank", 32'(w_b_blank), c_align ? 32'd1 : 32'd0);
    chk("b_42_hs",    32'(w_b_hs), 32'd1);
    step(4);
    chk("b_52_hs",    32'(w_b_hs), c_align ? 32'd1 : 32'd0);
    step(4);
    chk("b_62_hs",    32'(w_b_hs), c_align ? 32'd0 : 32'd1);
    step(36);
    chk("b_73_y",     32'(w_b_y), 32'd3);
    chk("b_73_vs",    32'(w_b_vs), 32'd1);
    step(4);
    chk("b_04_vs",    32'(w_b_vs), c_align ? 32'd1 : 32'd0);
    chk("b_04_ls",    32'(w_b_ls), 32'd1);
    chk("b_04_blank", 32'(w_b_blank), 32'd0);
    step(60);
    chk("b_75_vs",    32'(w_b_vs), 32'd0);
    step(4);
    chk("b_06_vs",    32'(w_b_vs), c_align ? 32'd0 : 32'd1);
    step(28);
    chk("b_76_x",     32'(w_b_x), 32'd7);
    chk("b_76_fs",    32'(w_b_fs), 32'd0);
    chk("b_76_fc",    32'(w_b_fc), 32'd1);
    step(4);
    chk("b_f2_xy",    32'({w_b_x, w_b_y}), 32'd0);
    chk("b_f2_fs",    32'(w_b_fs), 32'd1);
    chk("b_f2_fc",    32'(w_b_fc), 32'd2);
    step(253 * 224);
    chk("b_fc_255",   32'(w_b_fc), 32'd255);
    step(224);
    chk("b_fc_wrap",  32'(w_b_fc), 32'd0);
    chk("b_fc_wrap_fs", 32'(w_b_fs), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
